// File: rtl/div32u_seq_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package div32u_seq_pkg;

  localparam int          W_DEF  = 32;
  localparam int          ITER   = 32;
  localparam logic [31:0] DZ_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div32u_seq_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W:0]   diff;

  assign shifted = {rem_in, bit_in};

  // Adder-style subtract of the low W bits; carry-out set means no borrow.
  // A set top bit of the shifted remainder already guarantees the trial fits.
  assign diff    = {1'b0, shifted[W-1:0]} + {1'b0, ~divisor} + {{W{1'b0}}, 1'b1};
  assign q_bit   = shifted[W] | diff[W];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div32u_seq.sv
// Sequential unsigned divider, one quotient bit per clock (restoring).
// Optional macro DIV32U_DZ_FAST_EN: divide-by-zero completes on the accepting edge.
module div32u_seq
  import div32u_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_nx;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_nx;
  logic          q_bit;
  logic          dz_fast;

`ifdef DIV32U_DZ_FAST_EN
  assign dz_fast = (op2 == '0);
`else
  assign dz_fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = dz_fast ? DONE : RUN;
      RUN:        if (cnt == LAST) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  div_step #(.W(W)) u_step (
    .rem_in  (rem),
    .bit_in  (quo[W-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // quo doubles as the dividend shift register: its MSB feeds the step each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvs <= op2;
            cnt <= '0;
            if (dz_fast) begin
              quo <= '1;
              rem <= op1;
            end else begin
              quo <= op1;
              rem <= '0;
            end
          end
        end
        RUN: begin
          quo <= {quo[W-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_div32u_seq.sv
// Scoreboard bench for div32u_seq: stimulus pushes expectations, a monitor pops on each valid rise.
module tb_div32u_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] op1, op2;
  logic        busy, valid;
  logic [31:0] quo, rem;

  always #5 clk = ~clk;

  div32u_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op1   (op1),
    .op2   (op2),
    .busy  (busy),
    .valid (valid),
    .quo   (quo),
    .rem   (rem)
  );

`ifdef DIV32U_DZ_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Latency counted in edges including the accepting one.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1 && valid_q !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got quo=%h rem=%h expected no result", quo, rem);
      end else begin
        e = sb.pop_front();
        chk("quo", quo, e.q);
        chk("rem", rem, e.r);
        chk("latency", 32'(cyc - e.cyc + 1), 32'(e.lat));
      end
    end
    valid_q <= valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int lat);
    start = 1'b1;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{eq, er, cyc, lat});
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (valid !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: got valid=%b expected 1 within %0d cycles", valid, bound);
      sb.delete();
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    rst   = 1'b1;
    start = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_quo",   quo,        32'd0);
    chk("reset_rem",   rem,        32'd0);

    issue(32'd100, 32'd7, 32'd14, 32'd2, 33);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_valid(40);

    // Accepted in the cycle valid rose: valid must drop on that edge.
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    chk("b2b_valid_drop", 32'(valid), 32'd0);
    wait_valid(40);

    issue(32'd5, 32'd9, 32'd0, 32'd5, 33);
    wait_valid(40);
    issue(32'h8000_0000, 32'h10, 32'h0800_0000, 32'd0, 33);
    wait_valid(40);

    repeat (5) step();
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_quo",   quo,        32'h0800_0000);
    chk("hold_rem",   rem,        32'd0);

    // Divide by zero issued from IDLE so the valid rise is observable.
    pulse_rst();
    issue(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, DZ_LAT);
    wait_valid(40);

    // Second start while busy must be ignored.
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 33);
    repeat (8) step();
    start = 1'b1;
    op1   = 32'd9;
    op2   = 32'd9;
    step();
    start = 1'b0;
    chk("busy_ignore", 32'(busy), 32'd1);
    wait_valid(40);

    // Reset in cycle 15 of a run discards it.
    issue(32'd777, 32'd5, 32'd155, 32'd2, 33);
    repeat (13) step();
    pulse_rst();
    sb.delete();
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_quo",   quo,        32'd0);
    chk("midrst_rem",   rem,        32'd0);
    issue(32'd50, 32'd5, 32'd10, 32'd0, 33);
    wait_valid(40);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      issue(a, b, a / b, a % b, 33);
      wait_valid(40);
    end

    step();
    chk("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
